// File: rtl/cpu_run_if.sv
// cpu_run_if: control/status bundle between the run sequencer and its controller/datapath glue.
interface cpu_run_if;
    logic       start;
    logic       stop;
    logic       step_mode;
    logic       step;
    logic [3:0] pc;
    logic       alu_ovf;
    logic       set_pc;
    logic       exec_en;
    logic       running;
    logic       halted;
    logic [7:0] ins_count;
    logic       ovf_seen;
    logic [1:0] halt_cause;
    modport master (
        output start, stop, step_mode, step, pc, alu_ovf,
        input  set_pc, exec_en, running, halted, ins_count, ovf_seen, halt_cause
    );
    modport slave (
        input  start, stop, step_mode, step, pc, alu_ovf,
        output set_pc, exec_en, running, halted, ins_count, ovf_seen, halt_cause
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step sequencer for the 4-bit CPU; drives set_pc and exec_en,
// counts retired instructions and latches the halt cause and a sticky ALU overflow.
module cpu_run_ctrl #(
    parameter int MAX_INS     = 255,
    parameter int INIT_CYCLES = 1
) (
    input logic       clk,
    input logic       rst_n,
    cpu_run_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, STEP_WAIT, STEP_EXEC, HALT} state_t;
    state_t     state, nxt;
    logic [3:0] init_cnt;
    logic [3:0] last_pc;
    logic       last_valid;
    logic       step_q;
    logic       retire;
    logic       step_rise;
    logic       self_loop;
    logic       at_limit;
    logic [1:0] cause;
    assign retire    = state == RUN || state == STEP_EXEC;
    assign step_rise = bus.step & ~step_q;
    assign self_loop = last_valid && bus.pc == last_pc;
    assign at_limit  = {1'b0, bus.ins_count} + 9'd1 == 9'(MAX_INS);
    assign cause     = bus.stop ? 2'b01 : self_loop ? 2'b10 : at_limit ? 2'b11 : 2'b00;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = bus.start ? INIT : IDLE;
            INIT:      nxt = bus.stop ? HALT
                           : init_cnt == 4'(INIT_CYCLES - 1) ? (bus.step_mode ? STEP_WAIT : RUN)
                           : INIT;
            RUN:       nxt = cause != 2'b00 ? HALT : bus.step_mode ? STEP_WAIT : RUN;
            STEP_WAIT: nxt = bus.stop ? HALT : step_rise ? STEP_EXEC : !bus.step_mode ? RUN : STEP_WAIT;
            STEP_EXEC: nxt = cause != 2'b00 ? HALT : STEP_WAIT;
            HALT:      nxt = bus.start ? INIT : HALT;
            default:   nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            init_cnt       <= '0;
            last_pc        <= '0;
            last_valid     <= 1'b0;
            step_q         <= 1'b0;
            bus.set_pc     <= 1'b0;
            bus.exec_en    <= 1'b0;
            bus.running    <= 1'b0;
            bus.halted     <= 1'b0;
            bus.ins_count  <= '0;
            bus.ovf_seen   <= 1'b0;
            bus.halt_cause <= 2'b00;
        end else begin
            state       <= nxt;
            step_q      <= bus.step;
            bus.set_pc  <= nxt == INIT;
            bus.exec_en <= nxt == RUN || nxt == STEP_EXEC;
            bus.running <= nxt inside {INIT, RUN, STEP_WAIT, STEP_EXEC};
            bus.halted  <= nxt == HALT;
            if (nxt == INIT && state != INIT) begin
                init_cnt       <= '0;
                bus.ins_count  <= '0;
                bus.ovf_seen   <= 1'b0;
                bus.halt_cause <= 2'b00;
                last_valid     <= 1'b0;
            end else if (state == INIT) begin
                init_cnt <= init_cnt + 4'd1;
            end
            if (retire) begin
                bus.ins_count <= bus.ins_count + {7'd0, bus.ins_count != 8'hFF};
                last_pc       <= bus.pc;
                last_valid    <= 1'b1;
                bus.ovf_seen  <= bus.ovf_seen | bus.alu_ovf;
            end
            if (nxt == HALT && state != HALT)
                bus.halt_cause <= cause;
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: two sequencer instances (different limits/init lengths) share one stimulus
// stream and are compared every cycle against a behavioural run model.
module tb_cpu_run_ctrl;
    localparam int MAX_B  = 5;
    localparam int INIT_B = 3;
    localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_WAIT = 3, P_EXEC = 4, P_HALT = 5;

    typedef struct {
        int ph;
        int left;
        int ins;
        bit ovf;
        int cause;
        int last_pc;
        bit lv;
        bit sq;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_run_if if_a ();
    cpu_run_if if_b ();
    assign if_b.start     = if_a.start;
    assign if_b.stop      = if_a.stop;
    assign if_b.step_mode = if_a.step_mode;
    assign if_b.step      = if_a.step;
    assign if_b.pc        = if_a.pc;
    assign if_b.alu_ovf   = if_a.alu_ovf;

    cpu_run_ctrl #(.MAX_INS(255), .INIT_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    cpu_run_ctrl #(.MAX_INS(MAX_B), .INIT_CYCLES(INIT_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    logic [14:0] out_a, out_b;
    assign out_a = {if_a.set_pc, if_a.exec_en, if_a.running, if_a.halted, if_a.ins_count, if_a.ovf_seen, if_a.halt_cause};
    assign out_b = {if_b.set_pc, if_b.exec_en, if_b.running, if_b.halted, if_b.ins_count, if_b.ovf_seen, if_b.halt_cause};

    int   n_tests = 0;
    int   n_fail  = 0;
    int   pcv     = 0;
    int   pulses  = 0;
    mdl_t ma, mb;

    function automatic mdl_t m_reset();
        mdl_t m;
        m.ph = P_IDLE; m.left = 0; m.ins = 0; m.ovf = 0; m.cause = 0; m.last_pc = 0; m.lv = 0; m.sq = 0;
        return m;
    endfunction

    // Next run status given the inputs present at the coming clock edge.
    function automatic mdl_t m_next(mdl_t m, int maxi, int initc);
        mdl_t n = m;
        int   c;
        bit   rise;
        rise = if_a.step && !m.sq;
        n.sq = if_a.step;
        if (m.ph == P_RUN || m.ph == P_EXEC) begin
            n.ins     = m.ins < 255 ? m.ins + 1 : 255;
            n.last_pc = int'(if_a.pc);
            n.lv      = 1;
            n.ovf     = m.ovf | if_a.alu_ovf;
            c = if_a.stop ? 1 : (m.lv && int'(if_a.pc) == m.last_pc) ? 2 : (m.ins + 1 == maxi) ? 3 : 0;
            if (c != 0) begin
                n.ph = P_HALT; n.cause = c;
            end else
                n.ph = (m.ph == P_EXEC || if_a.step_mode) ? P_WAIT : P_RUN;
        end else if ((m.ph == P_IDLE || m.ph == P_HALT) && if_a.start) begin
            n.ph = P_INIT; n.left = initc; n.ins = 0; n.ovf = 0; n.cause = 0; n.lv = 0;
        end else if (m.ph == P_INIT) begin
            if (if_a.stop) begin
                n.ph = P_HALT; n.cause = 1;
            end else if (m.left == 1)
                n.ph = if_a.step_mode ? P_WAIT : P_RUN;
            else
                n.left = m.left - 1;
        end else if (m.ph == P_WAIT) begin
            if (if_a.stop) begin
                n.ph = P_HALT; n.cause = 1;
            end else if (rise)
                n.ph = P_EXEC;
            else if (!if_a.step_mode)
                n.ph = P_RUN;
        end
        return n;
    endfunction

    function automatic logic [14:0] m_out(mdl_t m);
        return {m.ph == P_INIT, m.ph == P_RUN || m.ph == P_EXEC,
                m.ph inside {P_INIT, P_RUN, P_WAIT, P_EXEC}, m.ph == P_HALT,
                8'(m.ins), m.ovf, 2'(m.cause)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model_a", {17'd0, out_a}, {17'd0, m_out(ma)});
        chk("model_b", {17'd0, out_b}, {17'd0, m_out(mb)});
        if (rst_n) begin
            ma = m_next(ma, 255, 1);
            mb = m_next(mb, MAX_B, INIT_B);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic tk();
        if_a.pc = 4'(pcv);
        pcv++;
        tick();
    endtask

    task automatic go();
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
    endtask

    initial begin
        int seq[5] = '{0, 1, 2, 3, 3};
        int sp[9]  = '{1, 1, 1, 0, 1, 0, 1, 0, 0};
        rst_n = 1'b0;
        if_a.start = 0; if_a.stop = 0; if_a.step_mode = 0; if_a.step = 0; if_a.pc = 0; if_a.alu_ovf = 0;
        ma = m_reset();
        mb = m_reset();
        tick();
        tick();
        chk("reset_outputs", {17'd0, out_a}, 32'd0);
        rst_n = 1'b1;
        tick();
        go();
        chk("init_set_pc", if_a.set_pc, 1);
        chk("init_exec_en", if_a.exec_en, 0);
        tick();
        chk("run_set_pc", if_a.set_pc, 0);
        chk("run_exec_en", if_a.exec_en, 1);
        for (int i = 0; i < 5; i++) begin
            if_a.pc = 4'(i);
            tick();
        end
        chk("run_ins5", if_a.ins_count, 5);
        chk("run_running", if_a.running, 1);
        tick();
        chk("selfloop_halted", if_a.halted, 1);
        chk("selfloop_cause", if_a.halt_cause, 2);
        chk("selfloop_ins", if_a.ins_count, 6);
        chk("selfloop_exec_off", if_a.exec_en, 0);
        go();
        tick();
        foreach (seq[k]) begin
            if_a.pc = 4'(seq[k]);
            tick();
        end
        chk("seq_ins", if_a.ins_count, 5);
        chk("seq_cause", if_a.halt_cause, 2);
        go();
        tick();
        for (int i = 0; i < 255; i++) begin
            if_a.pc = 4'(i % 16);
            tick();
        end
        chk("limit_ins", if_a.ins_count, 255);
        chk("limit_cause", if_a.halt_cause, 3);
        chk("limit_halted", if_a.halted, 1);
        go();
        chk("restart_ins", if_a.ins_count, 0);
        chk("restart_cause", if_a.halt_cause, 0);
        chk("restart_set_pc", if_a.set_pc, 1);
        if_a.step_mode = 1'b1;
        tick();
        chk("wait_exec_off", if_a.exec_en, 0);
        pcv = 0;
        foreach (sp[k]) begin
            if_a.step = sp[k][0];
            tk();
            pulses += int'(if_a.exec_en);
        end
        chk("step_pulses", pulses, 3);
        chk("step_ins", if_a.ins_count, 3);
        if_a.alu_ovf = 1'b1;
        tk();
        if_a.alu_ovf = 1'b0;
        chk("ovf_nonretire", if_a.ovf_seen, 0);
        if_a.step = 1'b1;
        tk();
        if_a.alu_ovf = 1'b1;
        tk();
        if_a.alu_ovf = 1'b0;
        if_a.step = 1'b0;
        chk("ovf_retire", if_a.ovf_seen, 1);
        chk("ovf_ins", if_a.ins_count, 4);
        if_a.step_mode = 1'b0;
        tk();
        if_a.pc = 4'd9;
        tick();
        if_a.stop = 1'b1;
        tick();
        if_a.stop = 1'b0;
        chk("stop_loop_cause", if_a.halt_cause, 1);
        chk("stop_loop_ins", if_a.ins_count, 6);
        go();
        tick();
        tk();
        tk();
        chk("pre_reset_running", if_a.running, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", {17'd0, out_a}, 32'd0);
        chk("async_reset_b", {17'd0, out_b}, 32'd0);
        ma = m_reset();
        mb = m_reset();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                ma = m_reset();
                mb = m_reset();
                tick();
                rst_n = 1'b1;
            end
            if_a.start = $urandom_range(0, 9) == 0;
            if_a.stop  = $urandom_range(0, 49) == 0;
            if ($urandom_range(0, 29) == 0) if_a.step_mode = ~if_a.step_mode;
            if_a.step    = $urandom_range(0, 2) == 0;
            if_a.pc      = $urandom_range(0, 5) == 0 ? if_a.pc : if_a.pc + 4'd1;
            if_a.alu_ovf = $urandom_range(0, 9) == 0;
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step sequencer for the 4-bit CPU datapath.
- Drives the datapath's set_pc (PC reset) and an exec_en clock-enable; the top-level gates datapath state updates with exec_en.
- Supports free-run, single-step and stop.
- Retires and counts instructions, detects halt conditions (branch-to-self, instruction limit) and records a sticky ALU overflow flag for the run.

Parameters:
- MAX_INS, 255: instruction-limit halt threshold (1..255).
- INIT_CYCLES, 1: cycles set_pc is held high at run start (1..15).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; begin a run from IDLE or HALT
- stop  input  1  level; request halt
- step_mode  input  1  1 = single-step, 0 = free-run
- step  input  1  level; each rising edge executes one instruction in step mode
- pc  input  4  current PC from the datapath
- alu_ovf  input  1  datapath ALU overflow
- set_pc  output  1  PC reset request to the datapath
- exec_en  output  1  instruction retires at this clock edge
- running  output  1  high in INIT/RUN/STEP_WAIT/STEP_EXEC
- halted  output  1  high in HALT
- ins_count  output  8  instructions retired this run
- ovf_seen  output  1  sticky: alu_ovf seen on any retiring cycle
- halt_cause  output  2  00 none, 01 stop, 10 self-loop, 11 limit

Behaviour:
- Reset (rst_n low, async): state=IDLE; set_pc=0, exec_en=0, running=0, halted=0, ins_count=0, ovf_seen=0, halt_cause=00; last_pc=0, last_valid=0, step edge register=0.
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Output decoding: Moore outputs decoded from the registered state only, so no combinational path from inputs to outputs.
  - set_pc=1 only in INIT.
  - exec_en=1 only in RUN and STEP_EXEC.
- States:
  - IDLE: start=1 -> INIT. stop ignored.
  - INIT: set_pc held for INIT_CYCLES cycles via an internal counter.
    - On entry, clear ins_count, ovf_seen, halt_cause and last_valid.
    - stop=1 -> HALT, cause 01.
    - After the last cycle: step_mode=1 -> STEP_WAIT, else -> RUN.
  - RUN: exec_en=1 every cycle. step_mode=1 -> STEP_WAIT.
  - STEP_WAIT: exec_en=0.
    - Rising edge of step (step & ~step_q) -> STEP_EXEC.
    - step_mode=0 -> RUN.
    - stop=1 -> HALT, cause 01.
  - STEP_EXEC: exactly one cycle, then -> STEP_WAIT unless halting.
  - HALT: halted=1; outputs hold. start=1 -> INIT, a fresh run.
- Retire edge (any edge with exec_en=1):
  - ins_count <= ins_count+1, saturating at 255.
  - last_pc <= pc; last_valid <= 1.
  - ovf_seen <= ovf_seen | alu_ovf.
- Halt evaluation on a retire edge, highest priority first:
  - stop=1 -> cause 01.
  - last_valid && pc==last_pc -> cause 10. The branch-to-self instruction therefore retires twice; both retires are counted.
  - ins_count+1 == MAX_INS -> cause 11.
  - Whichever fires -> HALT. exec_en is low from the next cycle.
- The instruction in the cycle stop is sampled in RUN still retires.
- start is ignored while running.
- step edges outside STEP_WAIT are discarded (step_q still tracks step).
- Reset mid-run aborts immediately: all outputs return to reset values asynchronously.

Test Plan:
- Reset then start=1 for 1 cycle, step_mode=0, INIT_CYCLES=1 -> set_pc high exactly 1 cycle, then exec_en high continuously; after 5 retires ins_count=5, running=1.
- Free-run with pc sequence 0,1,2,3,3 -> halt on the retire seeing pc=3 twice: halted=1, halt_cause=10, ins_count=5, exec_en=0 next cycle.
- MAX_INS=4, pc incrementing 0..15 -> HALT after 4th retire: ins_count=4, halt_cause=11. Then start -> ins_count=0, halt_cause=00, set_pc pulses.
- step_mode=1, step held high 3 cycles then low, then 2 more pulses -> exactly 3 exec_en pulses total, each 1 cycle wide; ins_count=3.
- alu_ovf=1 on one retire cycle and on a non-retire cycle in STEP_WAIT -> ovf_seen=1 only from the retire; a non-retire-only pulse leaves ovf_seen=0.
- stop=1 and self-loop on the same retire edge -> halt_cause=01, ins_count incremented. Also: rst_n low mid-RUN -> all outputs 0 without waiting for clk.
